// File: rtl/stopwatch_bcd.sv
// BCD stopwatch (mm:ss.cc) advanced by a synchronized divided-clock strobe,
// with start/stop and clear pushbuttons and a one-cycle rollover pulse.
module stopwatch_bcd #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [3:0] MAX_MIN_TENS = 4'd5
) (
  input  logic       fpga_clk,
  input  logic       rst,
  input  logic       clk_div,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] MIN_TENS_LIM = (MAX_MIN_TENS > 4'd9) ? 4'd9 : MAX_MIN_TENS;
  localparam logic [1:0] FLUSH_DONE   = 2'(SYNC_STAGES);

  // Input synchronizers, each followed by a history flop for edge detection
  logic [SYNC_STAGES-1:0] r_div_sync;
  logic [SYNC_STAGES-1:0] r_start_sync;
  logic [SYNC_STAGES-1:0] r_clear_sync;
  logic                   r_div_hist;
  logic                   r_start_hist;
  logic                   r_clear_hist;
  logic [1:0]             r_flush;
  logic                   r_start_armed;
  logic                   r_clear_armed;

  logic w_div_s;
  logic w_start_s;
  logic w_clear_s;
  logic w_flushed;
  logic w_tick;
  logic w_start_press;
  logic w_clear_press;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes a shift chain work.
  always_ff @(posedge fpga_clk or negedge rst) begin
    if (!rst) begin
      r_div_sync   <= '0;
      r_start_sync <= '1;
      r_clear_sync <= '1;
      r_div_hist   <= 1'b0;
      r_start_hist <= 1'b1;
      r_clear_hist <= 1'b1;
    end else begin
      r_div_sync   <= {r_div_sync[SYNC_STAGES-2:0], clk_div};
      r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], key_start_n};
      r_clear_sync <= {r_clear_sync[SYNC_STAGES-2:0], key_clear_n};
      r_div_hist   <= w_div_s;
      r_start_hist <= w_start_s;
      r_clear_hist <= w_clear_s;
    end
  end

  assign w_div_s   = r_div_sync[SYNC_STAGES-1];
  assign w_start_s = r_start_sync[SYNC_STAGES-1];
  assign w_clear_s = r_clear_sync[SYNC_STAGES-1];
  assign w_flushed = (r_flush == FLUSH_DONE);

  // A key only arms once the real pin level has reached the synchronizer output
  // and was seen released, so a key held through reset cannot fake a press.
  always_ff @(posedge fpga_clk or negedge rst) begin
    if (!rst) begin
      r_flush       <= 2'd0;
      r_start_armed <= 1'b0;
      r_clear_armed <= 1'b0;
    end else begin
      if (!w_flushed) begin
        r_flush <= r_flush + 2'd1;
      end
      r_start_armed <= r_start_armed | (w_flushed & w_start_s);
      r_clear_armed <= r_clear_armed | (w_flushed & w_clear_s);
    end
  end

  assign w_tick        = w_div_s & ~r_div_hist;
  assign w_start_press = r_start_armed & ~w_start_s & r_start_hist;
  assign w_clear_press = r_clear_armed & ~w_clear_s & r_clear_hist;

  // Control FSM
  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge fpga_clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    if (w_clear_press) begin
      w_state_next = S_IDLE;
    end else if (w_start_press) begin
      case (r_state)
        S_IDLE:  w_state_next = S_RUN;
        S_RUN:   w_state_next = S_PAUSE;
        S_PAUSE: w_state_next = S_RUN;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Digit chain
  logic [3:0] r_cs_ones;
  logic [3:0] r_cs_tens;
  logic [3:0] r_sec_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_min_ones;
  logic [3:0] r_min_tens;
  logic       r_running;
  logic       r_wrap;

  logic       w_advance;
  logic       w_c0;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;
  logic       w_c4;
  logic       w_c5;
  logic [3:0] w_cs_ones_nx;
  logic [3:0] w_cs_tens_nx;
  logic [3:0] w_sec_ones_nx;
  logic [3:0] w_sec_tens_nx;
  logic [3:0] w_min_ones_nx;
  logic [3:0] w_min_tens_nx;

  function automatic logic [3:0] step_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

  // w_cN: digits 0..N all sit at their wrap value, so digit N+1 advances
  assign w_c0 = (r_cs_ones >= 4'd9);
  assign w_c1 = w_c0 & (r_cs_tens  >= 4'd9);
  assign w_c2 = w_c1 & (r_sec_ones >= 4'd9);
  assign w_c3 = w_c2 & (r_sec_tens >= 4'd5);
  assign w_c4 = w_c3 & (r_min_ones >= 4'd9);
  assign w_c5 = w_c4 & (r_min_tens >= MIN_TENS_LIM);

  assign w_cs_ones_nx  = step_digit(r_cs_ones, 4'd9);
  assign w_cs_tens_nx  = w_c0 ? step_digit(r_cs_tens,  4'd9)         : r_cs_tens;
  assign w_sec_ones_nx = w_c1 ? step_digit(r_sec_ones, 4'd9)         : r_sec_ones;
  assign w_sec_tens_nx = w_c2 ? step_digit(r_sec_tens, 4'd5)         : r_sec_tens;
  assign w_min_ones_nx = w_c3 ? step_digit(r_min_ones, 4'd9)         : r_min_ones;
  assign w_min_tens_nx = w_c4 ? step_digit(r_min_tens, MIN_TENS_LIM) : r_min_tens;

  assign w_advance = (r_state == S_RUN) & w_tick;

  always_ff @(posedge fpga_clk or negedge rst) begin
    if (!rst) begin
      r_cs_ones  <= 4'd0;
      r_cs_tens  <= 4'd0;
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_running  <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      if (w_clear_press) begin
        r_cs_ones  <= 4'd0;
        r_cs_tens  <= 4'd0;
        r_sec_ones <= 4'd0;
        r_sec_tens <= 4'd0;
        r_min_ones <= 4'd0;
        r_min_tens <= 4'd0;
      end else if (w_advance) begin
        r_cs_ones  <= w_cs_ones_nx;
        r_cs_tens  <= w_cs_tens_nx;
        r_sec_ones <= w_sec_ones_nx;
        r_sec_tens <= w_sec_tens_nx;
        r_min_ones <= w_min_ones_nx;
        r_min_tens <= w_min_tens_nx;
      end
      // Registered from the next state so it tracks the state register exactly
      r_running <= (w_state_next == S_RUN);
      r_wrap    <= ~w_clear_press & w_advance & w_c5;
    end
  end

  assign cs_ones  = r_cs_ones;
  assign cs_tens  = r_cs_tens;
  assign sec_ones = r_sec_ones;
  assign sec_tens = r_sec_tens;
  assign min_ones = r_min_ones;
  assign min_tens = r_min_tens;
  assign running  = r_running;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: stimulus pushes expected display snapshots,
// a negedge monitor pops one each time the DUT outputs change.
module tb_stopwatch_bcd;

  logic       fpga_clk = 1'b0;
  logic       rst;
  logic       clk_div;
  logic       key_start_n;
  logic       key_clear_n;
  logic [3:0] cs_ones;
  logic [3:0] cs_tens;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       wrap;

  stopwatch_bcd #(.SYNC_STAGES(2), .MAX_MIN_TENS(4'd5)) dut (
    .fpga_clk    (fpga_clk),
    .rst         (rst),
    .clk_div     (clk_div),
    .key_start_n (key_start_n),
    .key_clear_n (key_clear_n),
    .cs_ones     (cs_ones),
    .cs_tens     (cs_tens),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .min_tens    (min_tens),
    .running     (running),
    .wrap        (wrap)
  );

  always #5 fpga_clk = ~fpga_clk;

  typedef struct packed {
    logic [23:0] disp;
    logic        run;
    logic        wrp;
  } snap_t;

  int    n_cmp       = 0;
  int    n_fail      = 0;
  int    wrap_cycles = 0;
  int    exp_wraps   = 0;
  int    m_cs        = 0;
  bit    m_run       = 1'b0;
  snap_t exp_q[$];
  snap_t exp_last    = '0;
  snap_t mon_prev    = '0;

  function automatic logic [23:0] bcd_of(input int cs);
    return {4'(cs / 60000), 4'((cs / 6000) % 10), 4'((cs / 1000) % 6),
            4'((cs / 100) % 10), 4'((cs / 10) % 10), 4'(cs % 10)};
  endfunction

  function automatic logic [23:0] dut_disp();
    return {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every observed change of {display, running, wrap} consumes one expectation
  always @(negedge fpga_clk) begin
    snap_t cur;
    cur = '{disp: dut_disp(), run: running, wrp: wrap};
    if (cur.wrp) wrap_cycles++;
    if (cur != mon_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_change: got %h, expected no change (t=%0t)", cur, $time);
      end else begin
        check("scoreboard", 32'(cur), 32'(exp_q.pop_front()));
      end
    end
    mon_prev = cur;
  end

  task automatic expect_now(input bit w);
    snap_t s;
    s = '{disp: bcd_of(m_cs), run: m_run, wrp: w};
    if (s != exp_last) begin
      exp_q.push_back(s);
      exp_last = s;
    end
  endtask

  task automatic advance(output bit w);
    w = 1'b0;
    if (m_run) begin
      m_cs++;
      if (m_cs == 360000) begin
        m_cs = 0;
        w    = 1'b1;
      end
    end
  endtask

  task automatic post_expect(input bit w);
    expect_now(w);
    if (w) begin
      exp_wraps++;
      expect_now(1'b0);
    end
  endtask

  // One stimulus vector: optional clk_div rise and key presses on the same cycle
  task automatic combo(input bit div, input bit start, input bit clr);
    bit w;
    w = 1'b0;
    @(negedge fpga_clk);
    clk_div     = div;
    key_start_n = ~start;
    key_clear_n = ~clr;
    if (clr) begin
      m_cs  = 0;
      m_run = 1'b0;
    end else begin
      if (div) advance(w);
      if (start) m_run = ~m_run;
    end
    post_expect(w);
    repeat (2) @(negedge fpga_clk);
    clk_div     = 1'b0;
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (3) @(negedge fpga_clk);
  endtask

  task automatic periods(input int n);
    for (int i = 0; i < n; i++) combo(1'b1, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    m_cs  = 0;
    m_run = 1'b0;
    expect_now(1'b0);
    @(posedge fpga_clk);
    #3 rst = 1'b0;
    #1;
    check("async_reset_disp", 32'(dut_disp()), 32'h0);
    check("async_reset_running", 32'(running), 32'h0);
    check("async_reset_wrap", 32'(wrap), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    rst         = 1'b0;
    clk_div     = 1'b0;
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (3) @(negedge fpga_clk);
    check("reset_disp", 32'(dut_disp()), 32'h0);
    check("reset_running", 32'(running), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge fpga_clk);

    // Run 250 ticks
    combo(1'b0, 1'b1, 1'b0);
    periods(250);
    check("run250_disp", 32'(dut_disp()), 32'h000250);
    check("run250_running", 32'(running), 32'h1);
    combo(1'b0, 1'b0, 1'b1);
    check("clear_disp", 32'(dut_disp()), 32'h0);

    // Pause / resume
    combo(1'b0, 1'b1, 1'b0);
    periods(100);
    combo(1'b0, 1'b1, 1'b0);
    check("pause_running", 32'(running), 32'h0);
    periods(20);
    check("pause_disp", 32'(dut_disp()), 32'h000100);
    combo(1'b0, 1'b1, 1'b0);
    periods(5);
    check("resume_disp", 32'(dut_disp()), 32'h000105);
    check("resume_running", 32'(running), 32'h1);

    // Tick and start together in RUN: one increment, then pause
    combo(1'b1, 1'b1, 1'b0);
    check("tick_start_disp", 32'(dut_disp()), 32'h000106);
    check("tick_start_running", 32'(running), 32'h0);

    // Clear, start and tick together: clear wins
    combo(1'b0, 1'b1, 1'b0);
    combo(1'b1, 1'b1, 1'b1);
    check("clear_prio_disp", 32'(dut_disp()), 32'h0);
    check("clear_prio_running", 32'(running), 32'h0);

    // Full rollover from 59:59.98
    combo(1'b0, 1'b1, 1'b0);
    @(negedge fpga_clk);
    m_cs = 359998;
    expect_now(1'b0);
    #1;
    force dut.r_min_tens = 4'd5;
    force dut.r_min_ones = 4'd9;
    force dut.r_sec_tens = 4'd5;
    force dut.r_sec_ones = 4'd9;
    force dut.r_cs_tens  = 4'd9;
    force dut.r_cs_ones  = 4'd8;
    #1;
    release dut.r_min_tens;
    release dut.r_min_ones;
    release dut.r_sec_tens;
    release dut.r_sec_ones;
    release dut.r_cs_tens;
    release dut.r_cs_ones;
    repeat (2) @(negedge fpga_clk);
    check("preload_disp", 32'(dut_disp()), 32'h595998);
    periods(1);
    check("max_disp", 32'(dut_disp()), 32'h595999);
    periods(1);
    check("rollover_disp", 32'(dut_disp()), 32'h0);
    check("rollover_running", 32'(running), 32'h1);

    // Asynchronous reset mid-count
    combo(1'b0, 1'b0, 1'b1);
    combo(1'b0, 1'b1, 1'b0);
    periods(37);
    check("pre_reset_disp", 32'(dut_disp()), 32'h000037);
    async_reset();
    @(negedge fpga_clk);
    rst = 1'b1;
    periods(10);
    check("post_reset_idle_disp", 32'(dut_disp()), 32'h0);
    combo(1'b0, 1'b1, 1'b0);
    periods(3);
    check("post_reset_run_disp", 32'(dut_disp()), 32'h000003);

    // Long key hold gives a single press
    combo(1'b0, 1'b0, 1'b1);
    @(negedge fpga_clk);
    key_start_n = 1'b0;
    m_run = 1'b1;
    expect_now(1'b0);
    repeat (1000) @(negedge fpga_clk);
    key_start_n = 1'b1;
    repeat (5) @(negedge fpga_clk);
    check("hold_running", 32'(running), 32'h1);

    // Sub-cycle clk_div glitch spanning an edge, then one between edges
    @(posedge fpga_clk);
    #7 clk_div = 1'b1;
    advance(w);
    post_expect(w);
    #6 clk_div = 1'b0;
    repeat (5) @(negedge fpga_clk);
    @(posedge fpga_clk);
    #2 clk_div = 1'b1;
    #4 clk_div = 1'b0;
    repeat (5) @(negedge fpga_clk);
    check("glitch_disp", 32'(dut_disp()), 32'h000001);

    // Key held low through reset release must not act as a press
    async_reset();
    repeat (2) @(negedge fpga_clk);
    key_start_n = 1'b0;
    repeat (2) @(negedge fpga_clk);
    rst = 1'b1;
    repeat (20) @(negedge fpga_clk);
    check("held_key_running", 32'(running), 32'h0);
    key_start_n = 1'b1;
    repeat (5) @(negedge fpga_clk);
    combo(1'b0, 1'b1, 1'b0);
    check("repress_running", 32'(running), 32'h1);

    repeat (5) @(negedge fpga_clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("wrap_cycles", 32'(wrap_cycles), 32'(exp_wraps));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for every asynchronous input; legal values are 2 or 3.
REQ-002 Parameter MAX_MIN_TENS, default 4'd5: highest minutes-tens digit before wrap.
REQ-003 fpga_clk  in  1  system clock; the only clock in the block.
REQ-004 rst  in  1  reset; asynchronous assert, active-low.
REQ-005 clk_div  in  1  divided clock from the upstream divider (nominal 100 Hz); treated as data, never used as a clock.
REQ-006 key_start_n  in  1  start/stop pushbutton; active-low; asynchronous to fpga_clk.
REQ-007 key_clear_n  in  1  clear pushbutton; active-low; asynchronous to fpga_clk.
REQ-008 cs_ones, cs_tens  out  4 each  BCD hundredths and tenths of a second.
REQ-009 sec_ones, sec_tens  out  4 each  BCD seconds.
REQ-010 min_ones, min_tens  out  4 each  BCD minutes.
REQ-011 running  out  1  high while the state is RUN.
REQ-012 wrap  out  1  one-cycle pulse on rollover from the maximum count to zero.

Function
REQ-013 clk_div, key_start_n and key_clear_n shall each pass through a SYNC_STAGES-flop synchronizer clocked by fpga_clk, followed by one history flop.
REQ-014 tick shall be the synchronized clk_div high with its history flop low; with SYNC_STAGES=2, the digits update on the 3rd fpga_clk rising edge after clk_div rises.
REQ-015 start_press and clear_press shall be one-cycle pulses on the synchronized falling edge (press) of their key; holding a key produces exactly one pulse.
REQ-016 FSM states: IDLE, RUN, PAUSE.
REQ-017 IDLE -> RUN on start_press; RUN -> PAUSE on start_press; PAUSE -> RUN on start_press.
REQ-018 clear_press from any state shall force IDLE and zero all digits on the next edge.
REQ-019 clear_press has priority over start_press and tick in the same cycle.
REQ-020 Digits shall advance only when the state is RUN and tick is high; in IDLE and PAUSE the digits hold.
REQ-021 If tick and start_press coincide in RUN, the digits increment once and the state becomes PAUSE.
REQ-022 Digit chain: cs_ones wraps at 9 to cs_tens; cs_tens wraps at 9 to sec_ones; sec_ones wraps at 9 to sec_tens; sec_tens wraps at 5 to min_ones; min_ones wraps at 9 to min_tens; min_tens wraps at MAX_MIN_TENS to 0.
REQ-023 A digit increments only when all lower digits wrap in the same cycle, and no digit ever holds a value above 9.
REQ-024 At 59:59.99 a tick shall produce 00:00.00, assert wrap for exactly one cycle, and keep the state RUN.
REQ-025 running shall be a registered output equal to (state == RUN).
REQ-026 All outputs shall be registered; no combinational path from any input to any output.

Reset
REQ-027 When rst=0, the block shall immediately set state=IDLE, all digits=0, running=0, wrap=0, synchronizer flops for clk_div=0 and synchronizer flops for keys=1 (released), regardless of the clock.
REQ-028 Reset asserted mid-count shall discard the count; after release the block waits in IDLE for start_press.
REQ-029 After reset release, a key held low since before the release shall not produce a press pulse until it is released and pressed again.

Verification
REQ-030 Reset, press start, apply 250 clk_div periods -> running=1, display 00:02.50, wrap never asserted.
REQ-031 Run to 00:01.00, press start, apply 20 clk_div periods, press start, apply 5 clk_div periods -> display 00:01.00 during the pause, then 00:01.05, running 1 -> 0 -> 1.
REQ-032 Preload via run to 59:59.98, apply 2 clk_div periods -> 59:59.99 then 00:00.00, wrap high for exactly 1 fpga_clk cycle, running=1.
REQ-033 In RUN, assert clear_press and start_press on the same cycle as a tick -> all digits 0, state IDLE, running=0, no increment.
REQ-034 At display 00:00.37 in RUN, assert rst low asynchronously between clock edges -> all outputs 0 before the next fpga_clk edge; after release, ticks do not change the display until start is pressed.
REQ-035 Hold key_start_n low for 1000 cycles while in IDLE -> exactly one transition to RUN; a 1-cycle glitch on clk_div shorter than one fpga_clk cycle -> at most one tick.
